alu_bist_ctrl: RTL

Built-in self-test sequencer for the fault-tolerant ALU stage. It sits directly upstream of the ALU's primary/spare wrapper and drives that wrapper's `test_en`, `test_done` and `lfsr_in` inputs. It generates a bounded burst of 32-bit pseudorandom patterns and closes the run with a `test_done` pulse. It then samples the wrapper's latched fault flag and reports pass/fail. Runs start on a `start` pulse or on an optional periodic timer, so the primary ALU is re-checked while the spare ALU serves live instructions.

---
 rtl/alu_bist_pkg.sv | 20 ++
 rtl/bist_lfsr32.sv | 36 +++
 rtl/alu_bist_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the ALU BIST sequencer: state encoding,
// LFSR polynomial taps and the default seed.
package alu_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    CHECK = 2'd3
  } state_e;

  // x^32 + x^22 + x^2 + x + 1 expressed as register bits 31, 21, 1, 0
  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_1234;

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {l[30:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bist_lfsr32.sv
// 32-bit Fibonacci LFSR pattern source; load has priority over step and
// reset returns the register to the seed.
module bist_lfsr32
  import alu_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] q
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = seed;
    end else if (step) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/alu_bist_ctrl.sv
// BIST sequencer for the primary/spare ALU wrapper: runs a burst of LFSR
// patterns, pulses test_done, then samples the wrapper's fault flag.
module alu_bist_ctrl
  import alu_bist_pkg::*;
#(
  parameter int unsigned N_PATTERNS  = 256,
  parameter logic [31:0] LFSR_SEED   = DEFAULT_SEED,
  parameter int unsigned AUTO_PERIOD = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        fault_in,
  output logic        test_en,
  output logic        test_done,
  output logic [31:0] lfsr_out,
  output logic        busy,
  output logic        pass,
  output logic        fail
);

  localparam int CNT_W = $clog2(N_PATTERNS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PATTERNS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             auto_trig;
  logic             go;

  assign go = start | auto_trig;

  // Idle timer exists only when periodic re-checking is enabled
  if (AUTO_PERIOD > 0) begin : g_auto
    localparam int TMR_W = $clog2(AUTO_PERIOD + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(AUTO_PERIOD - 1);

    logic [TMR_W-1:0] tmr_q, tmr_d;

    always_comb begin
      tmr_d = '0;
      if (state_q == IDLE && !go) begin
        tmr_d = tmr_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        tmr_q <= '0;
      end else begin
        tmr_q <= tmr_d;
      end
    end

    assign auto_trig = (state_q == IDLE) && (tmr_q == TMR_LAST);
  end else begin : g_no_auto
    assign auto_trig = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: state_d = CHECK;
      CHECK: begin
        pass_d  = ~fault_in;
        fail_d  = fail_q | fault_in;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  bist_lfsr32 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load ((state_q == IDLE) && go),
    .seed (LFSR_SEED),
    .step (state_q == RUN),
    .q    (lfsr_out)
  );

  assign test_en   = (state_q == RUN);
  assign test_done = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign pass      = pass_q;
  assign fail      = fail_q;

endmodule
